imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/loader_pkg.sv | 18 +
 rtl/imem_loader_if.sv | 24 ++
 rtl/byte_packer.sv | 39 +++
 rtl/imem_loader.sv | 136 +++++++++++++
 tb/tb_imem_loader.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
`timescale 1ns/1ps
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCheck,
    StRun,
    StErr
  } state_e;

  localparam logic [7:0]  DefaultSyncByte = 8'hA5;
  localparam int unsigned LenW            = 16;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream in, instruction RAM write port out.
`timescale 1ns/1ps
interface imem_loader_if #(
  parameter int unsigned AW = 8
) ();

  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_waddr, imem_wdata
  );

endinterface

// File: rtl/byte_packer.sv
// Packs little-endian bytes into 32-bit words and keeps a running XOR checksum.
`timescale 1ns/1ps
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  csum
);

  logic [1:0]  cnt_q;
  logic [23:0] shift_q;
  logic [7:0]  csum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
      csum_q  <= 8'd0;
    end else if (clear) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
      csum_q  <= 8'd0;
    end else if (en) begin
      cnt_q   <= cnt_q + 2'd1;
      // Newest byte enters at the top so byte 0 ends up in bits [7:0].
      shift_q <= {data, shift_q[23:8]};
      csum_q  <= csum_q ^ data;
    end
  end

  assign word_valid = en && (cnt_q == 2'd3);
  assign word       = {data, shift_q};
  assign csum       = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Receives a framed program image over a byte stream and writes it into instruction RAM.
`timescale 1ns/1ps
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter logic [7:0]  SYNC_BYTE = DefaultSyncByte
) (
  input  logic                clk,
  input  logic                reset,
  imem_loader_if.slave        bus,
  output logic                cpu_reset,
  output logic                loading,
  output logic                done,
  output logic                error
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  state_e          state_q, state_d;
  logic [LenW-1:0] len_q;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   waddr_q;
  logic [31:0]     wdata_q;
  logic            we_q;
  logic            ready_q;

  logic            accept;
  logic            is_sync;
  logic            restart;
  logic            clear;
  logic            pack_en;
  logic            word_valid;
  logic [31:0]     word;
  logic [7:0]      csum;
  logic [LenW-1:0] len_full;
  logic            last_word;

  assign accept    = bus.in_valid && ready_q;
  assign is_sync   = (bus.in_data == SYNC_BYTE);
  assign restart   = accept && is_sync;
  assign len_full  = {bus.in_data, len_q[7:0]};
  assign last_word = word_valid && (LenW'(addr_q) == len_q - LenW'(1));
  assign clear     = (state_d == StLenLo) && (state_q != StLenLo);
  assign pack_en   = accept && (state_q == StData);

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .en         (pack_en),
    .data       (bus.in_data),
    .word_valid (word_valid),
    .word       (word),
    .csum       (csum)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StRun, StErr: begin
        if (restart) state_d = StLenLo;
      end
      StLenLo: begin
        if (accept) state_d = StLenHi;
      end
      StLenHi: begin
        if (accept) begin
          if (len_full == '0)                        state_d = StCheck;
          else if (len_full > LenW'(MEM_DEPTH))      state_d = StErr;
          else                                       state_d = StData;
        end
      end
      StData: begin
        if (last_word) state_d = StCheck;
      end
      StCheck: begin
        if (accept) state_d = (bus.in_data == csum) ? StRun : StErr;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cpu_reset = 1'b1;
    loading   = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    unique case (state_q)
      StLenLo, StLenHi, StData, StCheck: loading = 1'b1;
      // A sync byte in RUN puts the core back into reset in the cycle it is accepted.
      StRun: begin
        cpu_reset = restart;
        done      = !restart;
      end
      StErr:   error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
    end else begin
      ready_q <= 1'b1;
      we_q    <= word_valid;
      if (word_valid) begin
        waddr_q <= addr_q;
        wdata_q <= word;
        addr_q  <= addr_q + AW'(1);
      end
      if (clear) addr_q <= '0;
      if (accept && (state_q == StLenLo)) len_q[7:0]  <= bus.in_data;
      if (accept && (state_q == StLenHi)) len_q[15:8] <= bus.in_data;
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed frames; expected RAM writes are queued and checked by a write monitor.
`timescale 1ns/1ps
module tb_imem_loader;

  logic clk;
  logic reset;
  logic cpu_reset;
  logic loading;
  logic done;
  logic error;

  int n_cmp;
  int n_fail;

  logic [39:0] exp_q[$];

  imem_loader_if #(.AW(8)) bus ();

  imem_loader #(
    .MEM_DEPTH (256),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .loading   (loading),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[7:0]);
    send(w[15:8]);
    send(w[23:16]);
    send(w[31:24]);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                 bus.imem_waddr, bus.imem_wdata);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(bus.imem_waddr), 32'(e[39:32]));
        chk("write_data", bus.imem_wdata, e[31:0]);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    reset = 1'b0;
    #13;
    chk("rst_in_ready",  32'(bus.in_ready),   32'd0);
    chk("rst_we",        32'(bus.imem_we),    32'd0);
    chk("rst_waddr",     32'(bus.imem_waddr), 32'd0);
    chk("rst_wdata",     bus.imem_wdata,      32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset),      32'd1);
    chk("rst_loading",   32'(loading),        32'd0);
    chk("rst_done",      32'(done),           32'd0);
    chk("rst_error",     32'(error),          32'd0);
    reset = 1'b1;
    idle(2);
    chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Two-word frame; XOR of 05 00 10 20 FF FF 00 10 is 0x25.
    send(8'hA5);
    chk("a_loading", 32'(loading),   32'd1);
    chk("a_cpu_rst", 32'(cpu_reset), 32'd1);
    send(8'h02);
    send(8'h00);
    push(8'd0, 32'h2010_0005);
    push(8'd1, 32'h1000_FFFF);
    send_word(32'h2010_0005);
    send_word(32'h1000_FFFF);
    chk("a_check_loading", 32'(loading), 32'd1);
    chk("a_check_done",    32'(done),    32'd0);
    send(8'h25);
    chk("a_done",    32'(done),      32'd1);
    chk("a_cpu_rst_low", 32'(cpu_reset), 32'd0);
    chk("a_error",   32'(error),     32'd0);
    chk("a_loading_low", 32'(loading), 32'd0);
    chk("a_drained", 32'(exp_q.size()), 32'd0);

    // Same frame from RUN, bad checksum.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    #1;
    chk("b_restart_cpu_rst", 32'(cpu_reset), 32'd1);
    chk("b_restart_done",    32'(done),      32'd0);
    @(posedge clk);
    #1;
    send(8'h02);
    send(8'h00);
    push(8'd0, 32'h2010_0005);
    push(8'd1, 32'h1000_FFFF);
    send_word(32'h2010_0005);
    send_word(32'h1000_FFFF);
    send(8'h00);
    chk("b_error",   32'(error),     32'd1);
    chk("b_cpu_rst", 32'(cpu_reset), 32'd1);
    chk("b_done",    32'(done),      32'd0);
    chk("b_drained", 32'(exp_q.size()), 32'd0);

    // Junk then an oversized length (257).
    send(8'h00);
    send(8'hFF);
    chk("c_junk_error", 32'(error), 32'd1);
    send(8'hA5);
    chk("c_sync_clears_error", 32'(error), 32'd0);
    chk("c_sync_loading",      32'(loading), 32'd1);
    send(8'h01);
    send(8'h01);
    chk("c_oversize_error",   32'(error),     32'd1);
    chk("c_oversize_loading", 32'(loading),   32'd0);
    chk("c_oversize_cpu_rst", 32'(cpu_reset), 32'd1);

    // Empty frame.
    send(8'hA5);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    chk("d_done",    32'(done),      32'd1);
    chk("d_cpu_rst", 32'(cpu_reset), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    #1;
    chk("d_restart_cpu_rst", 32'(cpu_reset), 32'd1);
    chk("d_restart_done",    32'(done),      32'd0);
    @(posedge clk);
    #1;
    chk("d_after_restart_loading", 32'(loading), 32'd1);

    // Reset mid-frame after six data bytes.
    send(8'h02);
    send(8'h00);
    push(8'd0, 32'h4433_2211);
    send_word(32'h4433_2211);
    send(8'h55);
    send(8'h66);
    #2;
    reset = 1'b0;
    #1;
    chk("e_in_ready", 32'(bus.in_ready),   32'd0);
    chk("e_we",       32'(bus.imem_we),    32'd0);
    chk("e_waddr",    32'(bus.imem_waddr), 32'd0);
    chk("e_wdata",    bus.imem_wdata,      32'd0);
    chk("e_cpu_rst",  32'(cpu_reset),      32'd1);
    chk("e_loading",  32'(loading),        32'd0);
    chk("e_done",     32'(done),           32'd0);
    chk("e_error",    32'(error),          32'd0);
    bus.in_valid = 1'b0;
    #5;
    reset = 1'b1;
    idle(2);
    chk("e_ready_back", 32'(bus.in_ready), 32'd1);
    chk("e_idle_loading", 32'(loading), 32'd0);
    // EF^BE^AD^DE = 0x22
    send(8'hA5);
    send(8'h01);
    send(8'h00);
    push(8'd0, 32'hDEAD_BEEF);
    send_word(32'hDEAD_BEEF);
    send(8'h22);
    chk("e_reload_done",    32'(done),      32'd1);
    chk("e_reload_cpu_rst", 32'(cpu_reset), 32'd0);
    chk("e_drained", 32'(exp_q.size()), 32'd0);

    // Full-depth frame; XOR of 0..255 is zero.
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    for (int i = 0; i < 256; i++) begin
      push(8'(i), 32'(i));
      send_word(32'(i));
    end
    send(8'h00);
    chk("f_done",    32'(done),      32'd1);
    chk("f_cpu_rst", 32'(cpu_reset), 32'd0);
    idle(5);
    chk("f_drained",    32'(exp_q.size()),   32'd0);
    chk("f_last_waddr", 32'(bus.imem_waddr), 32'h0000_00FF);
    chk("f_last_wdata", bus.imem_wdata,      32'h0000_00FF);
    chk("f_we_idle",    32'(bus.imem_we),    32'd0);
    chk("f_done_hold",  32'(done),           32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
